// File: rtl/mant_div_24.sv
// mant_div_24: sequential radix-2 restoring mantissa divider with start/done handshake
module mant_div_24 #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH:0]   quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  sticky,
    output logic                  dbz,
    output logic                  ovf
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [4:0]     cnt;
    logic [W:0]     r;
    logic [W-1:0]   d;
    logic [W-1:0]   qs;
    logic [W+1:0]   t;
    logic [W:0]     r_nxt;
    logic           q_bit, last, accept, is_dbz, is_ovf;

    // R < 2*D holds every iteration, so W+1 bits of R plus a sign bit suffice for the trial subtract
    assign t      = {1'b0, r} - {2'b0, d};
    assign q_bit  = ~t[W+1];
    assign r_nxt  = q_bit ? t[W:0] : r;
    assign last   = cnt == 5'd0;
    assign accept = start && (state == IDLE || state == DONE);
    assign is_dbz = divisor == '0;
    assign is_ovf = !is_dbz && ({1'b0, dividend} >= {divisor, 1'b0});
    assign busy   = state == RUN;
    assign done   = state == DONE;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state: early exits skip RUN, DONE lasts one cycle unless restarted
    always_comb begin
        state_nxt = state;
        if (accept)              state_nxt = (is_dbz || is_ovf) ? DONE : RUN;
        else if (state == RUN)   state_nxt = last ? DONE : RUN;
        else if (state == DONE)  state_nxt = IDLE;
    end

    // iteration datapath; result registers load only on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            r         <= '0;
            d         <= '0;
            qs        <= '0;
            quotient  <= '0;
            remainder <= '0;
            sticky    <= 1'b0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else if (accept) begin
            dbz <= is_dbz;
            ovf <= is_ovf;
            if (is_dbz || is_ovf) begin
                quotient  <= '1;
                remainder <= dividend;
                sticky    <= 1'b1;
            end else begin
                r   <= {1'b0, dividend};
                d   <= divisor;
                qs  <= '0;
                cnt <= 5'(W);
            end
        end else if (state == RUN) begin
            r   <= last ? r_nxt : {r_nxt[W-1:0], 1'b0};
            qs  <= {qs[W-2:0], q_bit};
            cnt <= cnt - 5'd1;
            if (last) begin
                quotient  <= {qs, q_bit};
                remainder <= r_nxt[W-1:0];
                sticky    <= |r_nxt;
            end
        end
    end
endmodule

// File: tb/tb_mant_div_24.sv
// tb_mant_div_24: scoreboard bench for mant_div_24 with directed and reference-checked vectors
module tb_mant_div_24;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] dividend = '0;
    logic [23:0] divisor = '0;
    logic        busy, done, sticky, dbz, ovf;
    logic [24:0] quotient;
    logic [23:0] remainder;

    typedef struct {
        logic [24:0] q;
        logic [23:0] r;
        logic        s;
        logic        z;
        logic        o;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    mant_div_24 dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .sticky(sticky), .dbz(dbz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("sticky", 32'(sticky), 32'(e.s));
                chk("dbz", 32'(dbz), 32'(e.z));
                chk("ovf", 32'(ovf), 32'(e.o));
            end
        end
    end

    task automatic issue(logic [23:0] a, logic [23:0] b, logic [24:0] eq, logic [23:0] er,
                         logic es, logic ez, logic eo, bit push);
        exp_t e;
        e = '{eq, er, es, ez, eo};
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (push) sb.push_back(e);
    endtask

    // waits for done after the accepting edge; optionally pokes a start mid-run
    task automatic wait_done(int exp_lat, int exp_busy, int poke);
        int k = 0;
        int nb = 0;
        bit seen = 0;
        @(posedge clk);
        #1 start = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (busy) nb++;
            if (done) seen = 1;
            if (!seen && k == poke) begin
                start = 1'b1;
                dividend = 24'h123456;
                divisor = 24'h9ABCDE;
            end else if (k == poke + 1) start = 1'b0;
        end
        if (seen) begin
            chk("latency", 32'(k - 1), 32'(exp_lat));
            chk("busy_cycles", 32'(nb), 32'(exp_busy));
        end else begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: got no done in 40 cycles expected done");
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] a, b;
        logic [47:0] num, q, rm;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_quotient", 32'(quotient), 0);
        chk("rst_remainder", 32'(remainder), 0);
        chk("rst_flags", {29'd0, sticky, dbz, ovf}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        issue(24'h800000, 24'h800000, 25'h1000000, 24'h0, 0, 0, 0, 1);
        wait_done(25, 25, 0);
        repeat (2) @(negedge clk);

        issue(24'h800000, 24'hC00000, 25'h0AAAAAA, 24'h800000, 1, 0, 0, 1);
        wait_done(25, 25, 0);
        issue(24'hC00000, 24'h800000, 25'h1800000, 24'h0, 0, 0, 0, 1);
        wait_done(25, 25, 0);
        repeat (2) @(negedge clk);

        issue(24'hFFFFFF, 24'h800000, 25'h1FFFFFE, 24'h0, 0, 0, 0, 1);
        wait_done(25, 25, 10);
        repeat (2) @(negedge clk);

        issue(24'h800000, 24'h400000, 25'h1FFFFFF, 24'h800000, 1, 0, 1, 1);
        wait_done(0, 0, 0);
        repeat (2) @(negedge clk);

        issue(24'h7FFFFF, 24'h400000, 25'h1FFFFFC, 24'h0, 0, 0, 0, 1);
        wait_done(25, 25, 0);
        repeat (2) @(negedge clk);

        issue(24'h123456, 24'h000000, 25'h1FFFFFF, 24'h123456, 1, 1, 0, 1);
        wait_done(0, 0, 0);
        repeat (2) @(negedge clk);

        issue(24'hFFFFFF, 24'h000001, 25'h1FFFFFF, 24'hFFFFFF, 1, 0, 1, 1);
        wait_done(0, 0, 0);
        repeat (2) @(negedge clk);

        issue(24'h800000, 24'hC00000, 25'h0, 24'h0, 0, 0, 0, 0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_quotient", 32'(quotient), 0);
        chk("arst_remainder", 32'(remainder), 0);
        chk("arst_flags", {29'd0, sticky, dbz, ovf}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        issue(24'hFFFFFF, 24'hFFFFFF, 25'h1000000, 24'h0, 0, 0, 0, 1);
        wait_done(25, 25, 0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            a = {1'b1, 23'($urandom)};
            b = {1'b1, 23'($urandom)};
            num = {a, 24'h0};
            q = num / {24'h0, b};
            rm = num - q * {24'h0, b};
            issue(a, b, q[24:0], rm[23:0], rm != 0, 0, 0, 1);
            wait_done(25, 25, 0);
            if (i[0]) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
